// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the timer/counter block.
//   cs   : clock select (stop, /1, /8, /64, /256, /1024; 6-7 also stop)
//   mode : counting mode (normal, clear-on-compare, up/down; 3 acts as normal)
//   com  : compare-output action on a compare match
//   TAP_*: number of low prescaler bits that must all be ones for a tick
package timer_pkg;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5
  } cs_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_CTC    = 2'd1,
    MODE_UPDOWN = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    COM_HOLD   = 2'd0,
    COM_TOGGLE = 2'd1,
    COM_CLEAR  = 2'd2,
    COM_SET    = 2'd3
  } com_e;

  localparam int TAP_DIV8    = 3;
  localparam int TAP_DIV64   = 6;
  localparam int TAP_DIV256  = 8;
  localparam int TAP_DIV1024 = 10;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running prescale counter and clock-select tick.
//   clock50 : system clock
//   MR      : synchronous active-high master reset (clears the prescaler)
//   psr     : prescaler reset (clears the prescaler, suppresses the tick)
//   cs      : clock select
//   tick    : combinational one-cycle timer tick for the current cycle
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PS_WIDTH = 10
) (
  input  logic       clock50,
  input  logic       MR,
  input  logic       psr,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [PS_WIDTH-1:0] ps_count;

  always_ff @(posedge clock50) begin
    if (MR || psr) begin
      ps_count <= '0;
    end else begin
      ps_count <= ps_count + 1'b1;
    end
  end

  // A divide-by-2^n tick fires when the low n prescaler bits are all ones,
  // so the first tick after a clear lands on prescaler value 2^n-1.
  always_comb begin
    tick = 1'b0;
    if (!psr) begin
      case (cs)
        CS_DIV1:    tick = 1'b1;
        CS_DIV8:    tick = &ps_count[TAP_DIV8-1:0];
        CS_DIV64:   tick = &ps_count[TAP_DIV64-1:0];
        CS_DIV256:  tick = &ps_count[TAP_DIV256-1:0];
        CS_DIV1024: tick = &ps_count[TAP_DIV1024-1:0];
        default:    tick = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/timer_counter.sv
// timer_counter: prescaled timer/counter with normal, CTC and up/down modes,
// parallel load, compare unit with waveform output and sticky flags.
//   clock50   : system clock
//   MR        : synchronous active-high master reset
//   cs        : clock select (see timer_pkg)
//   mode      : counting mode (see timer_pkg)
//   com       : compare output action (see timer_pkg)
//   ocr       : compare value, used directly every cycle
//   load_en   : parallel load strobe, load_val -> count
//   load_val  : parallel load value
//   psr       : prescaler reset
//   flag_clr  : write-1-to-clear, [0] TOV, [1] OCF
//   count_out : current count
//   tov_flag  : sticky overflow / bottom flag
//   ocf_flag  : sticky compare-match flag
//   oc_out    : compare waveform output
//   tick_out  : current-cycle tick (combinational)
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 10
) (
  input  logic             clock50,
  input  logic             MR,
  input  logic [2:0]       cs,
  input  logic [1:0]       mode,
  input  logic [1:0]       com,
  input  logic [WIDTH-1:0] ocr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             psr,
  input  logic [1:0]       flag_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             tov_flag,
  output logic             ocf_flag,
  output logic             oc_out,
  output logic             tick_out
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             tick;
  logic             dir;       // 0 = counting up, 1 = counting down
  logic             dir_next;
  logic             tov_set;
  logic             ocf_set;
  logic             oc_next;
  logic [WIDTH-1:0] count_next;

  timer_prescaler #(
    .PS_WIDTH(PS_WIDTH)
  ) u_prescaler (
    .clock50(clock50),
    .MR     (MR),
    .psr    (psr),
    .cs     (cs),
    .tick   (tick)
  );

  assign tick_out = tick;

  // Next-state for count, direction, flag set requests and waveform.
  // A load wins over a tick and suppresses compare/overflow/direction.
  always_comb begin
    count_next = count_out;
    dir_next   = dir;
    tov_set    = 1'b0;
    ocf_set    = 1'b0;
    oc_next    = oc_out;
    if (load_en) begin
      count_next = load_val;
    end else if (tick) begin
      if (count_out == ocr) begin
        ocf_set = 1'b1;
        case (com)
          COM_TOGGLE: oc_next = ~oc_out;
          COM_CLEAR:  oc_next = 1'b0;
          COM_SET:    oc_next = 1'b1;
          default:    oc_next = oc_out;
        endcase
      end
      case (mode)
        MODE_CTC: begin
          // With ocr == MAX the clear and the wrap coincide, so TOV still sets.
          if (count_out == ocr) begin
            count_next = '0;
          end else begin
            count_next = count_out + 1'b1;
          end
          tov_set = (count_out == MAX);
        end
        MODE_UPDOWN: begin
          if (!dir) begin
            if (count_out == MAX) begin
              count_next = MAX - 1'b1;
              dir_next   = 1'b1;
            end else begin
              count_next = count_out + 1'b1;
            end
          end else begin
            if (count_out == '0) begin
              count_next = {{(WIDTH-1){1'b0}}, 1'b1};
              dir_next   = 1'b0;
              tov_set    = 1'b1;
            end else begin
              count_next = count_out - 1'b1;
            end
          end
        end
        default: begin
          count_next = count_out + 1'b1;
          tov_set    = (count_out == MAX);
        end
      endcase
    end
    // Outside up/down mode the direction always returns to up.
    if (mode != MODE_UPDOWN) begin
      dir_next = 1'b0;
    end
  end

  always_ff @(posedge clock50) begin
    if (MR) begin
      count_out <= '0;
      dir       <= 1'b0;
      tov_flag  <= 1'b0;
      ocf_flag  <= 1'b0;
      oc_out    <= 1'b0;
    end else begin
      count_out <= count_next;
      dir       <= dir_next;
      // A set in the same cycle beats a clear.
      tov_flag  <= tov_set | (tov_flag & ~flag_clr[0]);
      ocf_flag  <= ocf_set | (ocf_flag & ~flag_clr[1]);
      oc_out    <= oc_next;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  localparam int W    = 8;
  localparam int PSW  = 10;
  localparam int MAXV = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  logic         mr;
  logic [2:0]   cs;
  logic [1:0]   mode;
  logic [1:0]   com;
  logic [W-1:0] ocr;
  logic         load_en;
  logic [W-1:0] load_val;
  logic         psr;
  logic [1:0]   flag_clr;
  logic [W-1:0] count_out;
  logic         tov_flag;
  logic         ocf_flag;
  logic         oc_out;
  logic         tick_out;

  timer_counter #(
    .WIDTH   (W),
    .PS_WIDTH(PSW)
  ) dut (
    .clock50  (clock50),
    .MR       (mr),
    .cs       (cs),
    .mode     (mode),
    .com      (com),
    .ocr      (ocr),
    .load_en  (load_en),
    .load_val (load_val),
    .psr      (psr),
    .flag_clr (flag_clr),
    .count_out(count_out),
    .tov_flag (tov_flag),
    .ocf_flag (ocf_flag),
    .oc_out   (oc_out),
    .tick_out (tick_out)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // reference model state
  int   m_count;
  int   m_ps;
  logic m_dir;
  logic m_tov;
  logic m_ocf;
  logic m_oc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic model_tick();
    if (psr) return 1'b0;
    case (cs)
      3'd1:    return 1'b1;
      3'd2:    return (m_ps % 8) == 7;
      3'd3:    return (m_ps % 64) == 63;
      3'd4:    return (m_ps % 256) == 255;
      3'd5:    return (m_ps % 1024) == 1023;
      default: return 1'b0;
    endcase
  endfunction

  // Inputs are set at posedge+1; this advances exactly one clock edge,
  // predicting the outputs into exp_q and comparing them after the edge.
  task automatic step(output logic tk_seen);
    logic tk, tov_set, ocf_set;
    logic [W+2:0] got, exp;
    int c;
    #1;
    tk = model_tick();
    tk_seen = tick_out;
    check("tick_out", tick_out, tk);
    if (mr) begin
      m_count = 0; m_dir = 0; m_tov = 0; m_ocf = 0; m_oc = 0;
    end else begin
      tov_set = 0;
      ocf_set = 0;
      c = m_count;
      if (load_en) begin
        m_count = load_val;
      end else if (tk) begin
        if (c == ocr) begin
          ocf_set = 1;
          case (com)
            2'd1: m_oc = !m_oc;
            2'd2: m_oc = 1'b0;
            2'd3: m_oc = 1'b1;
            default: ;
          endcase
        end
        if (mode == 2'd2) begin
          if (!m_dir) begin
            if (c == MAXV) begin m_count = MAXV - 1; m_dir = 1; end
            else m_count = c + 1;
          end else begin
            if (c == 0) begin m_count = 1; m_dir = 0; tov_set = 1; end
            else m_count = c - 1;
          end
        end else begin
          if (mode == 2'd1 && c == ocr) m_count = 0;
          else m_count = (c + 1) % (MAXV + 1);
          if (c == MAXV) tov_set = 1;
        end
      end
      if (mode != 2'd2) m_dir = 0;
      m_tov = tov_set || (m_tov && !flag_clr[0]);
      m_ocf = ocf_set || (m_ocf && !flag_clr[1]);
    end
    m_ps = (mr || psr) ? 0 : (m_ps + 1) % (1 << PSW);
    exp_q.push_back({m_count[W-1:0], m_tov, m_ocf, m_oc});
    @(posedge clock50);
    #1;
    got = {count_out, tov_flag, ocf_flag, oc_out};
    exp = exp_q.pop_front();
    check("obs{count,tov,ocf,oc}", got, exp);
  endtask

  task automatic run(input int n);
    logic t;
    for (int i = 0; i < n; i++) step(t);
  endtask

  task automatic set_idle();
    mr = 0; cs = 0; mode = 0; com = 0; ocr = 0;
    load_en = 0; load_val = 0; psr = 0; flag_clr = 0;
  endtask

  task automatic check_outs(input string name, input int c, input logic t, input logic o, input logic w);
    check({name, " count"}, count_out, c);
    check({name, " tov"}, tov_flag, t);
    check({name, " ocf"}, ocf_flag, o);
    check({name, " oc"}, oc_out, w);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         mr;
    logic [2:0]   cs;
    logic [1:0]   mode;
    logic [1:0]   com;
    logic [W-1:0] ocr;
    logic         load_en;
    logic [W-1:0] load_val;
    logic         psr;
    logic [1:0]   flag_clr;
    int           n;
    int           e_count;
    logic         e_tov;
    logic         e_ocf;
    logic         e_oc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic r, logic [2:0] c, logic [1:0] md, logic [1:0] cm, int oc,
                              logic ld, int lv, logic p, logic [1:0] fc, int n,
                              int ec, logic et, logic eo, logic ew);
    vec_t v;
    v.mr = r; v.cs = c; v.mode = md; v.com = cm; v.ocr = oc[W-1:0];
    v.load_en = ld; v.load_val = lv[W-1:0]; v.psr = p; v.flag_clr = fc; v.n = n;
    v.e_count = ec; v.e_tov = et; v.e_ocf = eo; v.e_oc = ew;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic t;
    //               mr cs  md com ocr  ld lval psr fc   n     cnt tov ocf oc
    vecs[0]  = mk(1, 0, 0, 0,   0, 0,   0, 0, 0,    1,    0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 1, 200, 0,   0, 0, 0,  256,    0, 1, 1, 1);
    vecs[2]  = mk(0, 0, 0, 1, 200, 0,   0, 0, 3,    1,    0, 0, 0, 1);
    vecs[3]  = mk(0, 3, 0, 1, 200, 0,   0, 1, 0,    1,    0, 0, 0, 1);
    vecs[4]  = mk(0, 3, 0, 1, 200, 0,   0, 0, 0,  128,    2, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 1, 200, 0,   0, 0, 0,   20,    2, 0, 0, 1);
    vecs[6]  = mk(1, 0, 0, 0,   0, 0,   0, 0, 0,    1,    0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 1,   9, 0,   0, 0, 0,   30,    0, 0, 1, 1);
    vecs[8]  = mk(0, 1, 2, 2, 255, 1, 200, 0, 0,    1,  200, 0, 1, 1);
    vecs[9]  = mk(0, 1, 2, 2, 255, 0,   0, 0, 0,  100,  210, 0, 1, 0);
    vecs[10] = mk(0, 1, 2, 2, 255, 0,   0, 0, 0,  300,   90, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 2, 255, 0,   0, 1, 3,    1,   90, 0, 0, 0);
    vecs[12] = mk(0, 2, 0, 3,  95, 0,   0, 0, 0,   48,   96, 0, 1, 1);
    vecs[13] = mk(0, 5, 3, 1,  97, 0,   0, 0, 0, 1100,   97, 0, 1, 1);
    vecs[14] = mk(0, 4, 3, 1,  97, 0,   0, 0, 2,  300,   98, 0, 0, 0);

    set_idle();
    mr = 1;
    m_count = 0; m_ps = 0; m_dir = 0; m_tov = 0; m_ocf = 0; m_oc = 0;
    @(posedge clock50);
    #1;

    for (int i = 0; i < 15; i++) begin
      mr = vecs[i].mr; cs = vecs[i].cs; mode = vecs[i].mode; com = vecs[i].com;
      ocr = vecs[i].ocr; load_en = vecs[i].load_en; load_val = vecs[i].load_val;
      psr = vecs[i].psr; flag_clr = vecs[i].flag_clr;
      run(vecs[i].n);
      check_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tov, vecs[i].e_ocf, vecs[i].e_oc);
    end

    // first /8 tick lands in the 8th cycle after reset release
    set_idle();
    mr = 1;
    step(t);
    check_outs("reset", 0, 0, 0, 0);
    mr = 0; cs = 3'd2;
    for (int i = 1; i <= 8; i++) begin
      step(t);
      check($sformatf("div8 tick cycle %0d", i), t, (i == 8));
    end
    check("div8 count", count_out, 1);

    // /64 after psr: count steps exactly on the 64th cycle
    cs = 3'd3; psr = 1;
    step(t);
    psr = 0;
    run(63);
    check("div64 before 64th", count_out, 1);
    run(1);
    check("div64 at 64th", count_out, 2);

    // load beats a compare match; flag set beats flag_clr
    set_idle();
    mr = 1;
    step(t);
    mr = 0; cs = 3'd1; ocr = 8'd64; load_en = 1; load_val = 8'd64;
    step(t);
    step(t);
    check_outs("load on match", 64, 0, 0, 0);
    load_en = 0;
    step(t);
    check_outs("match after load", 65, 0, 1, 0);
    load_en = 1; load_val = 8'd255;
    step(t);
    load_en = 0; flag_clr = 2'b11;
    step(t);
    check_outs("clr vs overflow", 0, 1, 0, 0);

    // MR mid-count with dir down, flags and oc set, load and tick active
    flag_clr = 0; mode = 2'd2; com = 2'd3; ocr = 8'd255; load_en = 1; load_val = 8'd255;
    step(t);
    load_en = 0;
    step(t);
    check_outs("updown top", 254, 1, 1, 1);
    load_en = 1; load_val = 8'd100;
    step(t);
    check_outs("load keeps state", 100, 1, 1, 1);
    mr = 1; load_val = 8'd77;
    step(t);
    check_outs("mr mid-count", 0, 0, 0, 0);
    mr = 0; load_en = 0;
    run(2);
    check_outs("dir up after mr", 2, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Parametrised timer/counter for the ATMega32A emulator, generalising the basic enable-driven counter. It adds a prescaler with AVR-style clock select, normal, clear-on-compare (CTC) and up/down modes, parallel load, a compare unit with a waveform output, and sticky overflow/compare flags. It sits behind the timer register file: the register file drives the control inputs and reads back the count and flags.

## Interface
- WIDTH, 8, counter and compare width (MAX = 2**WIDTH-1)
- PS_WIDTH, 10, prescaler counter width; must be ≥ 10 so the /1024 tap exists

- clock50  in  1  system clock; all state changes on its rising edge
- MR  in  1  master reset, synchronous, active-high
- cs  in  3  clock select: 0 stop, 1 /1, 2 /8, 3 /64, 4 /256, 5 /1024, 6–7 stop
- mode  in  2  0 normal, 1 CTC, 2 up/down, 3 treated as normal
- com  in  2  compare output action: 0 hold, 1 toggle, 2 clear, 3 set
- ocr  in  WIDTH  compare value, sampled every cycle (not buffered)
- load_en  in  1  parallel load strobe
- load_val  in  WIDTH  value written to the count on load_en
- psr  in  1  prescaler reset
- flag_clr  in  2  write-1-to-clear: [0] TOV, [1] OCF
- count_out  out  WIDTH  current count
- tov_flag  out  1  sticky overflow/bottom flag
- ocf_flag  out  1  sticky compare-match flag
- oc_out  out  1  compare waveform output
- tick_out  out  1  current-cycle timer tick (debug/cascade)

## Operation
- Prescaler: free-running PS_WIDTH-bit counter that increments every cycle. It is cleared by MR or psr; when cleared, it is 0 on the next cycle.
- Tick generation (combinational):
  - cs=1: tick=1 every cycle.
  - cs=2/3/4/5: tick=1 when the low 3/6/8/10 prescaler bits are all ones.
  - Otherwise, and in any cycle where psr=1: tick=0.
- Priority per edge: MR > load_en > tick > hold.
- Load: count←load_val. Compare, overflow and direction logic are suppressed for that cycle, and no flag or oc_out change occurs.
- Compare match: tick=1, no load, and count==ocr at the start of the cycle.
  - OCF is set.
  - oc_out is updated per com.
  - Applies in all modes.
- Normal mode: on each tick, count+1. At MAX it wraps to 0 and TOV is set.
- CTC mode: on each tick, if count==ocr then count←0; otherwise count+1 with wrap at MAX.
  - TOV is set only when the wrap occurs from MAX.
  - With ocr=MAX, CTC behaves like normal mode, and both flags set on the same edge.
- Up/down mode: direction register dir is 0 (up) after reset.
  - Up at MAX: count←MAX-1, dir←down.
  - Down at 0: count←1, dir←up, TOV set.
  - Otherwise: count±1.
  - A load keeps the current dir.
- Leaving up/down mode forces dir←up on the next edge.
- Flags: set has priority over flag_clr in the same cycle. A clear without a coincident set takes effect on the next edge.
- cs stop: count, dir, flags and oc_out hold. The prescaler keeps running.

## Timing
- Reset: count_out=0, dir=up, tov_flag=0, ocf_flag=0, oc_out=0, prescaler=0.
- All outputs are registered except tick_out.
- Latency from a tick cycle to the updated count_out, flags and oc_out: 1 edge.
- load_en latency: load_val appears on count_out after 1 edge.
- After reset release with cs=2, the first tick occurs with prescaler=7, i.e. in the 8th cycle after reset deasserts.
- An ocr change takes effect in the next cycle's compare.
- A change to cs, mode or com mid-count is glitch-free: only the tick/compare decision in the cycle of the change is affected.
- MR mid-count overrides everything on that edge.

## Structure
- Package timer_pkg:
  - cs encodings (CS_STOP, CS_DIV1 … CS_DIV1024)
  - mode encodings (MODE_NORMAL, MODE_CTC, MODE_UPDOWN)
  - com encodings (COM_HOLD, COM_TOGGLE, COM_CLEAR, COM_SET)
  - prescaler tap indices (3, 6, 8, 10)
- Sub-module timer_prescaler: ports clock50, MR, psr, cs → tick. It reuses the existing enable-counter style with a PS_WIDTH-bit count.
- The top level holds the count, direction, compare and flag logic.

## Test plan
- Reset/normal: MR 1 cycle; cs=1, mode=0, 256 cycles → count 0→255→0, tov_flag=1 one edge after the 255 cycle, ocf_flag set once.
- Prescale: cs=3, psr pulsed at t0 → count increments exactly every 64 cycles; first increment at the 64th cycle after psr; cs=0 freezes count.
- CTC + toggle: mode=1, ocr=9, com=1, cs=1 → count 0..9 repeating (period 10), oc_out toggles every 10 cycles, tov_flag stays 0.
- Up/down: mode=2, WIDTH=4, cs=1 → count 0,1..15,14..0,1..; tov_flag sets on the 0→1 turn; ocr=15 sets OCF once per 30-cycle period.
- Load/flag priority: load_en with load_val=ocr on a tick cycle → no OCF set. flag_clr=2'b11 on the same cycle as an overflow → tov_flag=1, ocf_flag cleared.
- Reset mid-operation: count=100, oc_out=1, flags set, MR asserted → next edge all outputs 0 and dir up regardless of load_en/tick.
